// File: rtl/seq_shift_alu.sv
// seq_shift_alu: x86-style shift/rotate unit that performs one 1-bit step per clock.
// Define SHIFT_COUNT_MASK_EN to mask the shift count to 5 bits (80186 behaviour).
module seq_shift_alu #(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [WIDTH-1:0]       a,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [15:0]            flags_in,
    output logic [WIDTH-1:0]       out,
    output logic [15:0]            flags_out,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SAR  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_RCL  = 3'd5;
    localparam logic [2:0] OP_RCR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1'b1);

    function automatic logic parity_even(input logic [7:0] v);
        return ~(^v);
    endfunction

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [2:0]             op_q, op_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic [15:0]            flags_q, flags_d;
    logic                   busy_q, done_q;
    logic [COUNT_WIDTH-1:0] eff_cnt_s;
    logic [WIDTH-1:0]       step_res_s;
    logic                   step_cf_s, step_of_s, is_shift_s;

`ifdef SHIFT_COUNT_MASK_EN
    assign eff_cnt_s = COUNT_WIDTH'(count[4:0]);
`else
    assign eff_cnt_s = count;
`endif

    assign is_shift_s = (op_q == OP_SHL) || (op_q == OP_SHR) || (op_q == OP_SAR);

    // One 1-bit step of the captured operation on the working value held in out_q.
    always_comb begin
        step_res_s = out_q;
        step_cf_s  = flags_q[0];
        step_of_s  = flags_q[11];
        case (op_q)
            OP_SHL: begin
                step_res_s = {out_q[WIDTH-2:0], 1'b0};
                step_cf_s  = out_q[WIDTH-1];
                step_of_s  = out_q[WIDTH-2] ^ out_q[WIDTH-1];
            end
            OP_SHR: begin
                step_res_s = {1'b0, out_q[WIDTH-1:1]};
                step_cf_s  = out_q[0];
                step_of_s  = out_q[WIDTH-1];
            end
            OP_SAR: begin
                step_res_s = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                step_cf_s  = out_q[0];
                step_of_s  = 1'b0;
            end
            OP_ROL: begin
                step_res_s = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                step_cf_s  = out_q[WIDTH-1];
                step_of_s  = out_q[WIDTH-2] ^ out_q[WIDTH-1];
            end
            OP_ROR: begin
                step_res_s = {out_q[0], out_q[WIDTH-1:1]};
                step_cf_s  = out_q[0];
                step_of_s  = out_q[0] ^ out_q[WIDTH-1];
            end
            // RCL/RCR treat {CF, value} as a WIDTH+1-bit rotate.
            OP_RCL: begin
                step_res_s = {out_q[WIDTH-2:0], flags_q[0]};
                step_cf_s  = out_q[WIDTH-1];
                step_of_s  = out_q[WIDTH-2] ^ out_q[WIDTH-1];
            end
            OP_RCR: begin
                step_res_s = {flags_q[0], out_q[WIDTH-1:1]};
                step_cf_s  = out_q[0];
                step_of_s  = flags_q[0] ^ out_q[WIDTH-1];
            end
            default: begin
                step_res_s = out_q;
                step_cf_s  = flags_q[0];
                step_of_s  = flags_q[11];
            end
        endcase
    end

    // Sequencing: capture on start, step while RUN, report in DONE.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        out_d   = out_q;
        flags_d = flags_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d    = op;
                    out_d   = a;
                    flags_d = flags_in;
                    if ((eff_cnt_s == '0) || (op == OP_PASS)) begin
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        rem_d   = eff_cnt_s;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                out_d       = step_res_s;
                flags_d[0]  = step_cf_s;
                flags_d[11] = step_of_s;
                if (is_shift_s) begin
                    flags_d[6] = (step_res_s == '0);
                    flags_d[7] = step_res_s[WIDTH-1];
                    flags_d[2] = parity_even(step_res_s[7:0]);
                end else begin
                    flags_d[6] = flags_q[6];
                    flags_d[7] = flags_q[7];
                    flags_d[2] = flags_q[2];
                end
                rem_d = rem_q - CNT_ONE;
                if (rem_q == CNT_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // State and output registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            op_q    <= 3'd0;
            out_q   <= '0;
            flags_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign out       = out_q;
    assign flags_out = flags_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_shift_alu.sv
// Self-checking bench for seq_shift_alu (WIDTH=16, COUNT_WIDTH=8): vector table,
// scoreboard queue, plus back-to-back, start-while-busy and mid-run reset sequences.
module tb_seq_shift_alu;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [7:0]  count;
    logic [15:0] flags_in;
    logic [15:0] out;
    logic [15:0] flags_out;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [7:0]  cnt;
        logic [15:0] fi;
        logic [15:0] exp_out;
        logic [15:0] exp_flags;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [15:0] flags;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    seq_shift_alu #(.WIDTH(16), .COUNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a),
        .count(count), .flags_in(flags_in), .out(out), .flags_out(flags_out),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency is counted in clock edges after the edge that samples start;
    // zero means done is already high right after that edge (N=0 / PASS).
    task automatic run_op(input logic [2:0] op_v, input logic [15:0] a_v, input logic [7:0] cnt_v,
                          input logic [15:0] fi_v, input logic [15:0] eo, input logic [15:0] ef,
                          input int el, input bit poke, input string tag);
        exp_t e;
        int   lat;
        int   bcnt;
        bit   seen;
        e.out = eo; e.flags = ef; e.lat = el;
        sb_q.push_back(e);
        op = op_v; a = a_v; count = cnt_v; flags_in = fi_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~a_v; flags_in = ~fi_v; count = cnt_v + 8'd1; op = ~op_v;
        lat = 0; bcnt = 0; seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
            if (poke && k == 0) begin
                start = 1'b1; op = 3'd7; a = 16'hFFFF; flags_in = 16'hFFFF; count = 8'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no done, expected done after %0d clocks", tag, e.lat);
        end else begin
            check({tag, "_out"}, {16'h0, out}, {16'h0, e.out});
            check({tag, "_flags"}, {16'h0, flags_out}, {16'h0, e.flags});
            check({tag, "_lat"}, lat, e.lat);
            check({tag, "_busycyc"}, bcnt, e.lat);
        end
    endtask

    // One idle cycle after a completed op: done must drop and results must hold.
    task automatic idle_check(input string tag, input logic [15:0] eo, input logic [15:0] ef);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, "_hold"}, {out, flags_out}, {eo, ef});
    endtask

    initial begin
        // op, a, count, flags_in, expected out, expected flags, latency
        vecs[0]  = '{3'd0, 16'h8001, 8'd1,  16'h0000, 16'h0002, 16'h0801, 1};
        vecs[1]  = '{3'd2, 16'h8000, 8'd4,  16'h0000, 16'hF800, 16'h0084, 4};
        vecs[2]  = '{3'd6, 16'h0001, 8'd1,  16'h00C5, 16'h8000, 16'h08C5, 1};
        vecs[3]  = '{3'd3, 16'h1234, 8'd0,  16'h0801, 16'h1234, 16'h0801, 0};
`ifdef SHIFT_COUNT_MASK_EN
        vecs[4]  = '{3'd1, 16'hFFFF, 8'd33, 16'h0000, 16'h7FFF, 16'h0805, 1};
`else
        vecs[4]  = '{3'd1, 16'hFFFF, 8'd33, 16'h0000, 16'h0000, 16'h0044, 33};
`endif
        vecs[5]  = '{3'd7, 16'hABCD, 8'd5,  16'hF8D5, 16'hABCD, 16'hF8D5, 0};
        vecs[6]  = '{3'd4, 16'h0001, 8'd1,  16'h0000, 16'h8000, 16'h0801, 1};
        vecs[7]  = '{3'd3, 16'h8000, 8'd1,  16'h0010, 16'h0001, 16'h0811, 1};
        vecs[8]  = '{3'd5, 16'h8000, 8'd2,  16'h0040, 16'h0001, 16'h0040, 2};
        vecs[9]  = '{3'd0, 16'h00FF, 8'd8,  16'h0010, 16'hFF00, 16'h0894, 8};
        vecs[10] = '{3'd4, 16'h1234, 8'd16, 16'h0045, 16'h1234, 16'h0044, 16};
        vecs[11] = '{3'd2, 16'h4000, 8'd15, 16'h0000, 16'h0000, 16'h0045, 15};

        reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 16'h0; count = 8'd0; flags_in = 16'h0;
        #12;
        check("rst_out", {16'h0, out}, 32'h0);
        check("rst_flags", {16'h0, flags_out}, 32'h0);
        check("rst_busy_done", {30'h0, busy, done}, 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].cnt, vecs[i].fi, vecs[i].exp_out,
                   vecs[i].exp_flags, vecs[i].exp_lat, 1'b0, $sformatf("vec%0d", i));
            idle_check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_flags);
        end

        // Back-to-back: second start is sampled in the DONE cycle of the first.
        run_op(3'd0, 16'h0001, 8'd1, 16'h0000, 16'h0002, 16'h0000, 1, 1'b0, "b2b_first");
        run_op(3'd1, 16'h0100, 8'd2, 16'h0000, 16'h0040, 16'h0000, 2, 1'b0, "b2b_second");
        idle_check("b2b", 16'h0040, 16'h0000);

        // start pulsed during RUN with different operands must be ignored.
        run_op(3'd0, 16'h0003, 8'd3, 16'h0000, 16'h0018, 16'h0004, 3, 1'b1, "busy_ignore");
        idle_check("busy_ignore", 16'h0018, 16'h0004);

        // Asynchronous reset in the middle of a ROR by 8.
        op = 3'd4; a = 16'h8421; count = 8'd8; flags_in = 16'h0FFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_out", {16'h0, out}, 32'h0);
        check("midrst_flags", {16'h0, flags_out}, 32'h0);
        check("midrst_busy_done", {30'h0, busy, done}, 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle", {30'h0, busy, done}, 32'h0);
        run_op(3'd0, 16'h0001, 8'd2, 16'h0000, 16'h0004, 16'h0000, 2, 1'b0, "postrst_shl");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
